// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one full-subtractor cell and a registered borrow; SERIAL_SUB_OVF_EN adds signed overflow.
// Latency WIDTH+1 cycles from accept to done; start is ignored while busy, and back-to-back accept happens from DONE.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, bo_q, bo_d;
  logic             d_bit, br_next, accept;

  assign d_bit   = ra_q[0] ^ rb_q[0] ^ br_q;
  assign br_next = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);
  assign accept  = start && (state_q != SHIFT);

`ifdef SERIAL_SUB_OVF_EN
  logic am_q, am_d, bm_q, bm_d, ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
`ifdef SERIAL_SUB_OVF_EN
      am_q    <= am_d;
      bm_q    <= bm_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    am_d    = am_q;
    bm_d    = bm_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: if (start) state_d = SHIFT;
      SHIFT: begin
        ra_d   = {1'b0, ra_q[WIDTH-1:1]};
        rb_d   = {1'b0, rb_q[WIDTH-1:1]};
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        br_d   = br_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          bo_d    = br_next;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (am_q != bm_q) & (d_bit != am_q);
`endif
        end
      end
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase

    // Accept overrides the IDLE/DONE hold values with a fresh operand load.
    if (accept) begin
      ra_d   = a;
      rb_d   = b;
      diff_d = '0;
      cnt_d  = '0;
      br_d   = 1'b0;
      bo_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am_d   = a[WIDTH-1];
      bm_d   = b[WIDTH-1];
      ovf_d  = 1'b0;
`endif
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`else
  assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expectations queued at drive time, compared on done.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow_out, ovf;
  logic [W-1:0] diff;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         bo;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int c);
    exp_t e;
    e.diff = x - y;
    e.bo   = (x < y);
`ifdef SERIAL_SUB_OVF_EN
    e.ovf  = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
`else
    e.ovf  = 1'b0;
`endif
    e.cyc  = c;
    return e;
  endfunction

  // Monitor: cycle counter plus scoreboard pop on every done pulse.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("diff", 32'(diff), 32'(mon_e.diff));
        check("borrow_out", 32'(borrow_out), 32'(mon_e.bo));
        check("ovf", 32'(ovf), 32'(mon_e.ovf));
        check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    start = 1'b1;
    sb_q.push_back(model(x, y, cyc + 1 + W));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * W && sb_q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of SHIFT: partial result dropped, no done afterwards.
    a = 8'h5A; b = 8'h10; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_diff", 32'(diff), 32'h0A0);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_diff", 32'(diff), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2 * W) @(posedge clk);
    #2;

    start_op(8'h5A, 8'h10);
    drain();
    start_op(8'h03, 8'h05);
    drain();
    start_op(8'h80, 8'h01);
    drain();
    start_op(8'hFF, 8'hFF);
    drain();
    start_op(8'h00, 8'hFF);
    drain();

    // Operand change and start pulse during SHIFT must be ignored.
    start_op(8'h33, 8'h11);
    repeat (3) @(posedge clk);
    #1;
    a = 8'h7F; b = 8'h80; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    // Back-to-back: start held through the op, new operands taken from DONE.
    begin
      int k0;
      a = 8'h10; b = 8'h20; start = 1'b1;
      k0 = cyc + 1;
      sb_q.push_back(model(8'h10, 8'h20, k0 + W));
      @(posedge clk);
      #1;
      a = 8'hC3; b = 8'h3C;
      sb_q.push_back(model(8'hC3, 8'h3C, k0 + W + 1 + W));
      repeat (W + 1) @(posedge clk);
      #1;
      start = 1'b0;
      drain();
    end

    for (int i = 0; i < 6; i++) begin
      start_op(W'($urandom), W'($urandom));
      drain();
    end

    repeat (3) @(posedge clk);
    #2;
    check("final_busy", 32'(busy), 32'd0);
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing `a - b` one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart of the team's ripple full-adder datapath. It is used where area matters more than latency, and a parent controller drives it with a start/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request to begin a subtraction; sampled only while `busy`=0.
- `a`  input  WIDTH  minuend; captured on the accepting edge.
- `b`  input  WIDTH  subtrahend; captured on the accepting edge.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  single-cycle pulse marking a valid result.
- `diff`  output  WIDTH  result `(a - b) mod 2^WIDTH`; held until the next accept.
- `borrow_out`  output  1  final borrow; 1 iff `a < b` unsigned.
- `ovf`  output  1  signed overflow flag; see Configuration.

## Operation
- FSM states:
  - IDLE: `busy`=0, `done`=0.
  - SHIFT: `busy`=1.
  - DONE: `busy`=0, `done`=1.
- Transitions:
  - IDLE -> SHIFT on `start`=1.
  - SHIFT -> DONE when the bit counter reaches WIDTH-1 at the processing edge.
  - DONE -> SHIFT if `start`=1, so back-to-back operation is supported.
  - DONE -> IDLE otherwise.
- Accept edge:
  - `a` and `b` load into internal shift registers `ra` and `rb`.
  - Borrow register `br` clears to 0, counter clears to 0.
  - The `diff` shift register clears to 0; `borrow_out` and `ovf` clear.
- Each SHIFT edge:
  - d = `ra[0]` ^ `rb[0]` ^ `br`.
  - Next `br` = (~`ra[0]` & `rb[0]`) | (~(`ra[0]` ^ `rb[0]`) & `br`).
  - `ra` and `rb` shift right by one.
  - d shifts into `diff` at the MSB, with `diff` shifting right.
  - Counter increments.
- Last SHIFT edge: `borrow_out` takes the next `br` value; `diff` is complete.
- `start` while `busy`=1 is ignored; operands are not re-sampled.
- Reset asserted at any time, including mid-SHIFT:
  - FSM to IDLE immediately; all registers to 0.
  - Any partial result is discarded, and no `done` pulse is issued.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, `ovf`=0.
- Edge E0 samples `start`=1 with `busy`=0. `busy` rises after E0.
- Edges E1..E_WIDTH each process one bit.
- After E_WIDTH:
  - `busy`=0 and `done`=1 for exactly one cycle.
  - `diff`, `borrow_out` and `ovf` are valid.
- Latency from accept edge to `done` is WIDTH+1 clock cycles inclusive of E0's cycle. Throughput is one operation per WIDTH+1 cycles when `start` is held high.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `SERIAL_SUB_OVF_EN`.
- Defined:
  - The MSBs of `a` and `b` are retained at accept.
  - On the last SHIFT edge, `ovf` = (a_msb != b_msb) & (d != a_msb), where d is the final result bit.
  - `ovf` is cleared on accept and on reset.
- Undefined: `ovf` is tied to constant 0 and no extra registers are built. The port is always present.

## Test plan
- Reset mid-op:
  - Stimulus: WIDTH=8, `a`=0x5A, `b`=0x10, `start` pulse; assert `rst_n`=0 after 4 SHIFT edges.
  - Required: `busy`, `diff` and `done` go to 0 immediately, with no `done` pulse after release.
- Basic subtraction:
  - Stimulus: `a`=0x5A, `b`=0x10, `start` for one cycle.
  - Required: `done` arrives 9 cycles after accept, with `diff`=0x4A, `borrow_out`=0, `ovf`=0.
- Borrow and wrap-around:
  - Stimulus: `a`=0x03, `b`=0x05.
  - Required: `diff`=0xFE, `borrow_out`=1, `ovf`=0.
- Signed overflow:
  - Stimulus: `a`=0x80, `b`=0x01.
  - Required: `diff`=0x7F, `borrow_out`=0, `ovf`=1 with the macro defined and 0 without it.
- Ignored start and back-to-back:
  - Stimulus: change `a`/`b` and pulse `start` during SHIFT.
  - Required: the result reflects the original operands.
  - Stimulus: hold `start`=1 with new operands at the `done` cycle.
  - Required: the next operation is accepted with no IDLE cycle, and the second `done` arrives 9 cycles later.
- Edge operands:
  - Stimulus: `a`=`b`=0xFF.
  - Required: `diff`=0x00, `borrow_out`=0.
  - Stimulus: `a`=0x00, `b`=0xFF.
  - Required: `diff`=0x01, `borrow_out`=1.
